// File: rtl/usb_cdc_byte_fifo.sv
// First-word-fall-through byte FIFO with level, threshold and error flags.
// Shared by the CDC RX and TX paths of usb_cdc_wrapper.
module usb_cdc_byte_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          rd,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] level,
    input  logic [AW-1:0] th,
    output logic          full,
    output logic          empty,
    output logic          level_above,
    output logic          level_below,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW-1:0] MAXL = '1;
    localparam logic [AW-1:0] ONE  = AW'(1);

    logic [DW-1:0] r_mem [2**AW];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_level;
    logic          r_ovf;
    logic          r_unf;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    assign w_full   = (r_level == MAXL);
    assign w_empty  = (r_level == '0);
    // A pop frees the slot in the same edge, so a full FIFO still takes a push.
    assign w_wr_acc = wr & (~w_full | rd) & ~flush;
    assign w_rd_acc = rd & ~w_empty & ~flush;

    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_ovf <= wr & w_full & ~rd;
            r_unf <= rd & w_empty;
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + ONE;
            if (w_rd_acc)
                r_rd_ptr <= r_rd_ptr + ONE;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + ONE;
                2'b01:   r_level <= r_level - ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    assign rdata       = w_empty ? '0 : r_mem[r_rd_ptr];
    assign level       = r_level;
    assign full        = w_full;
    assign empty       = w_empty;
    assign level_above = (r_level > th);
    assign level_below = (r_level < th);
    assign overflow    = r_ovf;
    assign underflow   = r_unf;

endmodule

// File: doc/usb_cdc_byte_fifo.md
Name: usb_cdc_byte_fifo

Overview:
- Single-clock, first-word-fall-through byte FIFO with level and threshold flags.
- Instantiated twice inside usb_cdc_wrapper: once as the RX FIFO between the CDC bulk-OUT endpoint and the bus wrapper, once as the TX FIFO between the bus wrapper and the bulk-IN endpoint.
- Its level, full/empty and threshold outputs drive the bus-wrapper level registers and RIS flags directly.
- rdata is valid in the same cycle as the bus read strobe.

Parameters:
- DW, 8, data width in bits.
- AW, 4, pointer width. Storage is 2**AW entries; usable capacity is 2**AW-1 (15 by default) so that level fits in AW bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents, pointers and level.
- wr  in  1  push strobe; one byte per cycle while high.
- wdata  in  DW  push data, sampled when wr=1.
- rd  in  1  pop strobe; discards the head entry.
- rdata  out  DW  head entry, valid while empty=0; 0 when empty.
- level  out  AW  number of stored entries, 0..2**AW-1.
- th  in  AW  threshold for the level comparisons.
- full  out  1  level == 2**AW-1.
- empty  out  1  level == 0.
- level_above  out  1  level > th.
- level_below  out  1  level < th.
- overflow  out  1  one-cycle pulse: write dropped because the FIFO was full.
- underflow  out  1  one-cycle pulse: read ignored because the FIFO was empty.

Behaviour:
- Reset values (async on rst=1):
  - wr_ptr=0, rd_ptr=0, level=0.
  - empty=1, full=0, level_above=0.
  - level_below=(th!=0), overflow=0, underflow=0.
  - rdata=0.
  - Memory contents are not reset.
- Storage: register array of 2**AW x DW, written on clk.
- Pointers are AW bits and wrap naturally from 2**AW-1 to 0.
- Accept conditions:
  - A write is accepted when wr=1 and (full=0 or rd=1).
  - A read is accepted when rd=1 and empty=0.
- Accepted write: mem[wr_ptr]<=wdata, wr_ptr<=wr_ptr+1.
- Accepted read: rd_ptr<=rd_ptr+1.
- Level update at the clock edge: +1 for accepted write only; -1 for accepted read only; unchanged for both or neither.
- Simultaneous wr and rd:
  - When full: both are accepted; level stays 2**AW-1; the old head leaves and the new byte enters at the tail.
  - When empty: the write is accepted, the read is rejected with an underflow pulse, and level becomes 1.
- Rejected accesses:
  - wr=1, full=1, rd=0: data dropped, state unchanged, overflow=1 for the next cycle.
  - rd=1, empty=1: state unchanged, underflow=1 for the next cycle.
  - overflow and underflow are registered and self-clear after one cycle.
- FWFT timing:
  - rdata = empty ? 0 : mem[rd_ptr], combinational from registered state.
  - A byte written at edge N is visible on rdata after edge N when the FIFO was empty.
  - Caller samples rdata in the same cycle it asserts rd.
- Flags (full, empty, level_above, level_below) are combinational from the registered level and th.
  - A th change takes effect in the same cycle.
  - th=0: level_below is always 0.
  - th=2**AW-1: level_above is always 0.
- flush has priority over wr and rd in the same cycle:
  - Pointers and level go to 0.
  - No overflow or underflow pulse is generated.
  - An accompanying write is discarded.
- Reset asserted mid-operation: immediate return to reset values regardless of pending wr/rd; the first access after rst deasserts behaves as on an empty FIFO.
- No combinational path from wr or rd to any output.

Test Plan:
- Reset with th=4 -> empty=1, full=0, level=0, level_below=1, level_above=0, rdata=0; then wr=1 with wdata=0xA5 for 1 cycle -> next cycle level=1, empty=0, rdata=0xA5.
- Fill with 0x00..0x0E (15 writes), then one more write of 0xFF -> full=1, level=15, overflow pulses for exactly 1 cycle; then drain 15 reads -> rdata sequence 0x00..0x0E in order (0xFF never appears), empty=1 at end.
- Wrap test: 10 writes, 10 reads, repeated 3 times with distinct data -> data order preserved across pointer wrap, level returns to 0 each round.
- Full plus simultaneous wr=1 (0x55) and rd=1 -> level stays 15, no overflow, old head removed, 0x55 read last after draining.
- Empty plus wr=1 (0x3C) and rd=1 -> underflow pulses, level=1, rdata=0x3C; rd on empty alone -> underflow 1 cycle, level stays 0.
- th=3: after 3 writes level_above=0 and level_below=0, 4th write -> level_above=1; flush with wr=1 -> level=0, empty=1, level_below=1, no overflow or underflow pulse; assert rst at level=7 -> outputs at reset values immediately.
